// File: rtl/ip_hdr_sched.sv
// ip_hdr_sched
//   Sequencer in front of the IP header builder. It arbitrates two frame
//   requesters (0 = ultrasonic data, 1 = command reply) and one IP-config
//   requester. Builder strobes are two cycles wide, and their data is already
//   stable one cycle before the strobe rises. The block waits for the builder
//   ready pulse, then starts the MAC transmit and waits for it to finish.
//
//   Optional build macro IP_SCHED_STATS_EN:
//     defined   - o_frame_cnt counts successful frames and saturates at 16'hFFFF
//     undefined - o_frame_cnt is tied to zero
//
//   Ports:
//     i_clk, i_rst                 clock, asynchronous active-high reset
//     i_req, i_len0, i_len1        frame requests (level) and payload lengths
//     o_gnt, o_done, o_len_err     accept / finish / oversize-reject pulses
//     i_cfg_req, i_cfg_sel,
//     i_cfg_ip, o_cfg_ack          IP config request, selector, address, ack
//     o_trig, o_set_local,
//     o_set_dest                   builder strobes (registered)
//     o_data_length, o_ip0..o_ip3  builder data (o_ip0 = MSB)
//     i_hdr_ready                  builder done pulse
//     o_tx_start, o_tx_src,
//     i_tx_done                    MAC handshake and the requester index
//     o_busy, o_timeout_err        status; o_timeout_err is sticky until reset
//     o_frame_cnt                  successful frame count (optional)
//
//   GAP_CYCLES must be at least 1.

module ip_hdr_sched #(
    parameter logic [15:0] MAX_LEN        = 16'd1480,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req,
    input  logic [15:0] i_len0,
    input  logic [15:0] i_len1,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_done,
    output logic        o_len_err,
    input  logic        i_cfg_req,
    input  logic        i_cfg_sel,
    input  logic [31:0] i_cfg_ip,
    output logic        o_cfg_ack,
    output logic        o_trig,
    output logic        o_set_local,
    output logic        o_set_dest,
    output logic [15:0] o_data_length,
    output logic [7:0]  o_ip0,
    output logic [7:0]  o_ip1,
    output logic [7:0]  o_ip2,
    output logic [7:0]  o_ip3,
    input  logic        i_hdr_ready,
    output logic        o_tx_start,
    output logic        o_tx_src,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic        o_timeout_err,
    output logic [15:0] o_frame_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StCfgDrive,
        StCfgWait,
        StHdrTrig,
        StHdrWait,
        StTxStart,
        StTxWait,
        StGap
    } state_e;

    // One counter serves the strobe phases, the ready timeout and the gap.
    localparam int unsigned CntMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 3);

    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);
    // Phase 0 sets up the data; phases 1 and 2 carry the strobe.
    localparam logic [CntW-1:0] StrobeLast  = CntW'(2);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              rej_q, rej_d;
    logic              sel_q, sel_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              len_err_q, len_err_d;
    logic              cfg_ack_q, cfg_ack_d;
    logic              trig_q, trig_d;
    logic              set_local_q, set_local_d;
    logic              set_dest_q, set_dest_d;
    logic [15:0]       data_len_q, data_len_d;
    logic [31:0]       ip_q, ip_d;
    logic              tx_start_q, tx_start_d;
    logic              tx_src_q, tx_src_d;
    logic              timeout_q, timeout_d;

    logic              win;
    logic [15:0]       len_sel;
    logic [1:0]        src_onehot;

    assign src_onehot = tx_src_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        rej_d       = rej_q;
        sel_d       = sel_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        len_err_d   = 1'b0;
        cfg_ack_d   = 1'b0;
        trig_d      = 1'b0;
        set_local_d = 1'b0;
        set_dest_d  = 1'b0;
        data_len_d  = data_len_q;
        ip_d        = ip_q;
        tx_start_d  = 1'b0;
        tx_src_d    = tx_src_q;
        timeout_d   = timeout_q;
        win         = 1'b0;
        len_sel     = 16'd0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (i_cfg_req) begin
                    sel_d   = i_cfg_sel;
                    ip_d    = i_cfg_ip;
                    state_d = StCfgDrive;
                end else if (|i_req) begin
                    // rr_q names the requester that wins a tie.
                    win      = (i_req == 2'b11) ? rr_q : i_req[1];
                    len_sel  = win ? i_len1 : i_len0;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    tx_src_d = win;
                    if (len_sel > MAX_LEN) begin
                        rej_d      = 1'b1;
                        data_len_d = 16'd0;
                    end else begin
                        rej_d      = 1'b0;
                        data_len_d = len_sel;
                    end
                    state_d = StHdrTrig;
                end
            end

            StCfgDrive: begin
                if (cnt_q == StrobeLast) begin
                    state_d = StCfgWait;
                    cnt_d   = '0;
                end else begin
                    set_local_d = ~sel_q;
                    set_dest_d  = sel_q;
                    cnt_d       = cnt_q + CntW'(1);
                end
            end

            StCfgWait: begin
                if (i_hdr_ready) begin
                    cfg_ack_d = 1'b1;
                    ip_d      = '0;
                    state_d   = StGap;
                    cnt_d     = '0;
                end else if (cnt_q == TimeoutLast) begin
                    cfg_ack_d = 1'b1;
                    timeout_d = 1'b1;
                    ip_d      = '0;
                    state_d   = StGap;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StHdrTrig: begin
                if (cnt_q == '0 && rej_q) begin
                    // Oversize: report it one cycle after the grant; the builder
                    // never sees a trigger.
                    done_d    = src_onehot;
                    len_err_d = 1'b1;
                    state_d   = StGap;
                    cnt_d     = '0;
                end else if (cnt_q == StrobeLast) begin
                    state_d = StHdrWait;
                    cnt_d   = '0;
                end else begin
                    trig_d = 1'b1;
                    cnt_d  = cnt_q + CntW'(1);
                end
            end

            StHdrWait: begin
                if (i_hdr_ready) begin
                    tx_start_d = 1'b1;
                    data_len_d = 16'd0;
                    state_d    = StTxStart;
                end else if (cnt_q == TimeoutLast) begin
                    done_d     = src_onehot;
                    timeout_d  = 1'b1;
                    data_len_d = 16'd0;
                    state_d    = StGap;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StTxStart: begin
                state_d = StTxWait;
            end

            StTxWait: begin
                if (i_tx_done) begin
                    done_d  = src_onehot;
                    rr_d    = ~rr_q;
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end

            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            rej_q       <= 1'b0;
            sel_q       <= 1'b0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            len_err_q   <= 1'b0;
            cfg_ack_q   <= 1'b0;
            trig_q      <= 1'b0;
            set_local_q <= 1'b0;
            set_dest_q  <= 1'b0;
            data_len_q  <= 16'd0;
            ip_q        <= 32'd0;
            tx_start_q  <= 1'b0;
            tx_src_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            rej_q       <= rej_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
            cfg_ack_q   <= cfg_ack_d;
            trig_q      <= trig_d;
            set_local_q <= set_local_d;
            set_dest_q  <= set_dest_d;
            data_len_q  <= data_len_d;
            ip_q        <= ip_d;
            tx_start_q  <= tx_start_d;
            tx_src_q    <= tx_src_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef IP_SCHED_STATS_EN
    logic [15:0] frame_cnt_q;
    logic        frame_inc;

    // Same condition that produces the successful o_done pulse.
    assign frame_inc = (state_q == StTxWait) && i_tx_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q <= 16'd0;
        end else if (frame_inc && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`else
    assign o_frame_cnt = 16'd0;
`endif

    assign o_gnt         = gnt_q;
    assign o_done        = done_q;
    assign o_len_err     = len_err_q;
    assign o_cfg_ack     = cfg_ack_q;
    assign o_trig        = trig_q;
    assign o_set_local   = set_local_q;
    assign o_set_dest    = set_dest_q;
    assign o_data_length = data_len_q;
    assign o_ip0         = ip_q[31:24];
    assign o_ip1         = ip_q[23:16];
    assign o_ip2         = ip_q[15:8];
    assign o_ip3         = ip_q[7:0];
    assign o_tx_start    = tx_start_q;
    assign o_tx_src      = tx_src_q;
    assign o_busy        = (state_q != StIdle);
    assign o_timeout_err = timeout_q;

endmodule

// File: tb/tb_ip_hdr_sched.sv
// Self-checking bench for ip_hdr_sched. Frames and config requests are issued
// with random lengths, builder and MAC latencies. The expected results come
// from a transaction-level model: arbitration winner, reject rule, strobe
// widths, timeout latency, sticky error flag and frame count.

module tb_ip_hdr_sched;

    localparam int          TO   = 64;
    localparam int          GAP  = 2;
    localparam logic [15:0] MAXL = 16'd1480;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [1:0]  i_req = 2'b00;
    logic [15:0] i_len0 = 16'd0;
    logic [15:0] i_len1 = 16'd0;
    logic        i_cfg_req = 1'b0;
    logic        i_cfg_sel = 1'b0;
    logic [31:0] i_cfg_ip = 32'd0;
    logic        i_hdr_ready = 1'b0;
    logic        i_tx_done = 1'b0;
    logic [1:0]  o_gnt, o_done;
    logic        o_len_err, o_cfg_ack, o_trig, o_set_local, o_set_dest;
    logic [15:0] o_data_length, o_frame_cnt;
    logic [7:0]  o_ip0, o_ip1, o_ip2, o_ip3;
    logic        o_tx_start, o_tx_src, o_busy, o_timeout_err;

    ip_hdr_sched dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_len0        (i_len0),
        .i_len1        (i_len1),
        .o_gnt         (o_gnt),
        .o_done        (o_done),
        .o_len_err     (o_len_err),
        .i_cfg_req     (i_cfg_req),
        .i_cfg_sel     (i_cfg_sel),
        .i_cfg_ip      (i_cfg_ip),
        .o_cfg_ack     (o_cfg_ack),
        .o_trig        (o_trig),
        .o_set_local   (o_set_local),
        .o_set_dest    (o_set_dest),
        .o_data_length (o_data_length),
        .o_ip0         (o_ip0),
        .o_ip1         (o_ip1),
        .o_ip2         (o_ip2),
        .o_ip3         (o_ip3),
        .i_hdr_ready   (i_hdr_ready),
        .o_tx_start    (o_tx_start),
        .o_tx_src      (o_tx_src),
        .i_tx_done     (i_tx_done),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_rr = 1'b0;
    bit          m_to = 1'b0;
    int          m_frames = 0;
    logic [1:0]  pend = 2'b00;
    logic [15:0] plen [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef IP_SCHED_STATS_EN
        return 32'(m_frames);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [15:0] rand_len();
        case ($urandom_range(0, 7))
            0:       return MAXL;
            1:       return MAXL + 16'd1;
            2:       return 16'($urandom_range(32'(MAXL) + 1, 65535));
            default: return 16'($urandom_range(0, 32'(MAXL)));
        endcase
    endfunction

    task automatic drive_req();
        i_req  = pend;
        i_len0 = plen[0];
        i_len1 = plen[1];
    endtask

    // Called at the negedge of the done/ack cycle, which is the first gap cycle.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy === 1'b1 && n < 20) begin
            check_eq({tag, "_gap_strobe"},
                     32'({o_trig, o_set_local, o_set_dest, o_tx_start}), 32'd0);
            n++;
            @(negedge i_clk);
        end
        check_eq({tag, "_gap_len"}, 32'(n), 32'(GAP));
        check_eq({tag, "_to_sticky"}, 32'(o_timeout_err), 32'(m_to));
    endtask

    task automatic run_cfg(input bit sel, input logic [31:0] ip, input int d, input bit never);
        int n;
        logic [1:0] exp_set;
        exp_set   = sel ? 2'b01 : 2'b10;
        i_cfg_req = 1'b1;
        i_cfg_sel = sel;
        i_cfg_ip  = ip;
        @(negedge i_clk);
        check_eq("cfg_busy", 32'(o_busy), 32'd1);
        check_eq("cfg_no_gnt", 32'(o_gnt), 32'd0);
        check_eq("cfg_ip", {o_ip0, o_ip1, o_ip2, o_ip3}, ip);
        check_eq("cfg_set_pre", 32'({o_set_local, o_set_dest}), 32'd0);
        @(negedge i_clk);
        check_eq("cfg_set_1", 32'({o_set_local, o_set_dest}), 32'(exp_set));
        @(negedge i_clk);
        check_eq("cfg_set_2", 32'({o_set_local, o_set_dest}), 32'(exp_set));
        @(negedge i_clk);
        check_eq("cfg_set_off", 32'({o_set_local, o_set_dest}), 32'd0);
        if (never) begin
            n = 0;
            while (o_cfg_ack !== 1'b1 && n < 200) begin
                @(negedge i_clk);
                n++;
            end
            check_eq("cfg_to_lat", 32'(n), 32'(TO));
            check_eq("cfg_to_err", 32'(o_timeout_err), 32'd1);
            m_to = 1'b1;
        end else begin
            repeat (d - 2) @(negedge i_clk);
            check_eq("cfg_ip_hold", {o_ip0, o_ip1, o_ip2, o_ip3}, ip);
            check_eq("cfg_early_ack", 32'(o_cfg_ack), 32'd0);
            i_hdr_ready = 1'b1;
            @(negedge i_clk);
            i_hdr_ready = 1'b0;
            check_eq("cfg_ack", 32'(o_cfg_ack), 32'd1);
        end
        i_cfg_req = 1'b0;
        check_eq("cfg_ip_clr", {o_ip0, o_ip1, o_ip2, o_ip3}, 32'd0);
        check_eq("cfg_no_done", 32'(o_done), 32'd0);
        wait_idle("cfg");
    endtask

    // Starts at an idle negedge with pend already driven.
    task automatic run_frame(input int d, input bit never, input int t);
        int          n;
        bit          w;
        logic [1:0]  oh;
        logic [15:0] len;
        w   = (pend == 2'b11) ? m_rr : pend[1];
        oh  = w ? 2'b10 : 2'b01;
        len = plen[w];
        @(negedge i_clk);
        check_eq("gnt", 32'(o_gnt), 32'(oh));
        check_eq("gnt_src", 32'(o_tx_src), 32'(w));
        check_eq("gnt_no_trig", 32'(o_trig), 32'd0);
        pend[w] = 1'b0;
        drive_req();
        if (len > MAXL) begin
            @(negedge i_clk);
            check_eq("rej_done", 32'({o_done, o_len_err}), 32'({oh, 1'b1}));
            check_eq("rej_no_trig", 32'(o_trig), 32'd0);
            wait_idle("rej");
            return;
        end
        @(negedge i_clk);
        check_eq("trig_1", 32'(o_trig), 32'd1);
        check_eq("data_len", 32'(o_data_length), 32'(len));
        @(negedge i_clk);
        check_eq("trig_2", 32'(o_trig), 32'd1);
        @(negedge i_clk);
        check_eq("trig_off", 32'(o_trig), 32'd0);
        check_eq("data_len_hold", 32'(o_data_length), 32'(len));
        if (never) begin
            n = 0;
            while (o_done === 2'b00 && n < 200) begin
                @(negedge i_clk);
                n++;
            end
            check_eq("hdr_to_lat", 32'(n), 32'(TO));
            check_eq("hdr_to_done", 32'({o_done, o_len_err}), 32'({oh, 1'b0}));
            check_eq("hdr_to_err", 32'(o_timeout_err), 32'd1);
            m_to = 1'b1;
            wait_idle("hdr_to");
            return;
        end
        repeat (d - 2) @(negedge i_clk);
        check_eq("early_tx", 32'(o_tx_start), 32'd0);
        i_hdr_ready = 1'b1;
        @(negedge i_clk);
        i_hdr_ready = 1'b0;
        check_eq("tx_start", 32'(o_tx_start), 32'd1);
        check_eq("tx_src", 32'(o_tx_src), 32'(w));
        check_eq("data_len_clr", 32'(o_data_length), 32'd0);
        repeat (t) @(negedge i_clk);
        check_eq("tx_wait_quiet", 32'({o_done, o_tx_start}), 32'd0);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        check_eq("done", 32'({o_done, o_len_err}), 32'({oh, 1'b0}));
        m_rr = ~m_rr;
        m_frames++;
        check_eq("frame_cnt", 32'(o_frame_cnt), exp_cnt());
        wait_idle("frame");
    endtask

    initial begin
        plen[0] = 16'd0;
        plen[1] = 16'd0;
        repeat (3) @(negedge i_clk);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_pulses", 32'({o_gnt, o_done, o_len_err, o_cfg_ack, o_tx_start}), 32'd0);
        check_eq("rst_strobes", 32'({o_trig, o_set_local, o_set_dest}), 32'd0);
        check_eq("rst_data", 32'(o_data_length), 32'd0);
        check_eq("rst_ip", {o_ip0, o_ip1, o_ip2, o_ip3}, 32'd0);
        check_eq("rst_status", 32'({o_tx_src, o_timeout_err}), 32'd0);
        check_eq("rst_cnt", 32'(o_frame_cnt), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Contention: config and both frame requests raised together.
        pend    = 2'b11;
        plen[0] = 16'd300;
        plen[1] = 16'd700;
        drive_req();
        run_cfg(1'b0, 32'hC0A8010A, 12, 1'b0);
        for (int k = 0; k < 4; k++) begin
            pend = 2'b11;
            drive_req();
            run_frame(6 + k, 1'b0, 2 + k);
        end
        pend = 2'b00;
        drive_req();
        @(negedge i_clk);

        // Single frame, then oversize reject and the exact limit.
        pend    = 2'b01;
        plen[0] = 16'd100;
        drive_req();
        run_frame(8, 1'b0, 4);
        pend    = 2'b10;
        plen[1] = 16'd1481;
        drive_req();
        run_frame(5, 1'b0, 2);
        pend    = 2'b01;
        plen[0] = MAXL;
        drive_req();
        run_frame(3, 1'b0, 1);

        // Builder never ready, then a normal frame.
        pend    = 2'b01;
        plen[0] = 16'd64;
        drive_req();
        run_frame(2, 1'b1, 1);
        pend    = 2'b10;
        plen[1] = 16'd20;
        drive_req();
        run_frame(2, 1'b0, 1);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            bit do_cfg;
            do_cfg = ($urandom_range(0, 4) == 0);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    plen[r] = rand_len();
                end
            end
            if (!do_cfg && pend == 2'b00) begin
                pend[0] = 1'b1;
                plen[0] = rand_len();
            end
            drive_req();
            if (do_cfg) begin
                run_cfg(1'($urandom_range(0, 1)), $urandom, $urandom_range(2, 15),
                        $urandom_range(0, 15) == 0);
            end else begin
                run_frame($urandom_range(2, 15), $urandom_range(0, 11) == 0,
                          $urandom_range(1, 8));
            end
        end
        pend = 2'b00;
        drive_req();
        @(negedge i_clk);

        // Reset during TX_WAIT with the tie pointer favouring requester 1.
        if (!m_rr) begin
            pend    = 2'b01;
            plen[0] = 16'd50;
            drive_req();
            run_frame(4, 1'b0, 2);
        end
        pend    = 2'b01;
        plen[0] = 16'd200;
        drive_req();
        @(negedge i_clk);
        check_eq("abort_gnt", 32'(o_gnt), 32'd1);
        pend = 2'b00;
        drive_req();
        repeat (3) @(negedge i_clk);
        i_hdr_ready = 1'b1;
        @(negedge i_clk);
        i_hdr_ready = 1'b0;
        check_eq("abort_tx_start", 32'(o_tx_start), 32'd1);
        @(negedge i_clk);
        check_eq("abort_txwait", 32'(o_busy), 32'd1);
        pend    = 2'b11;
        plen[0] = 16'd40;
        plen[1] = 16'd80;
        drive_req();
        i_rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(o_busy), 32'd0);
        check_eq("arst_pulses", 32'({o_gnt, o_done, o_len_err, o_cfg_ack, o_tx_start}), 32'd0);
        check_eq("arst_status", 32'({o_tx_src, o_timeout_err, o_trig}), 32'd0);
        check_eq("arst_data", 32'(o_data_length), 32'd0);
        check_eq("arst_cnt", 32'(o_frame_cnt), 32'd0);
        m_rr     = 1'b0;
        m_to     = 1'b0;
        m_frames = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
        run_frame(6, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ip_hdr_sched.md
Name: ip_hdr_sched

Overview:
- Controller in front of the IP header builder: sequences its trigger and set-IP strobes, waits for its ready pulse, then hands the finished header to the MAC transmit path.
- Arbitrates two frame requesters (0 = ultrasonic data, 1 = command reply) and one IP-config requester, and guarantees the builder only ever sees clean rising edges.

Parameters:
- MAX_LEN, 16'd1480: largest accepted payload length in bytes; anything longer is rejected.
- TIMEOUT_CYCLES, 64: cycles to wait for i_hdr_ready before aborting.
- GAP_CYCLES, 2: idle cycles with all strobes low between transactions.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_req  in  2  frame request per requester, level, held until its o_gnt bit
- i_len0  in  16  payload length for requester 0, valid while i_req[0]
- i_len1  in  16  payload length for requester 1, valid while i_req[1]
- o_gnt  out  2  one-cycle pulse: request accepted, length latched
- o_done  out  2  one-cycle pulse: frame finished or rejected
- o_len_err  out  1  one-cycle pulse with o_done on an oversize reject
- i_cfg_req  in  1  IP config request, level, held until o_cfg_ack
- i_cfg_sel  in  1  0 = set local IP, 1 = set destination IP
- i_cfg_ip  in  32  new IP, MSB first; stable while i_cfg_req
- o_cfg_ack  out  1  one-cycle pulse when config completes
- o_trig, o_set_local, o_set_dest  out  1 each  builder strobes, registered
- o_data_length  out  16  payload length to builder
- o_ip0..o_ip3  out  8 each  IP bytes to builder (o_ip0 = MSB)
- i_hdr_ready  in  1  builder done pulse
- o_tx_start  out  1  one-cycle pulse to MAC
- o_tx_src  out  1  requester index of the current frame
- i_tx_done  in  1  MAC finished frame
- o_busy  out  1  high whenever state is not IDLE
- o_timeout_err  out  1  sticky; cleared only by reset
- o_frame_cnt  out  16  see Optional Feature

Behaviour:
- Reset (async): every output is 0 and the state is IDLE. The round-robin pointer is set so that requester 0 wins first. Reset mid-transaction aborts it silently with no done/ack pulse.
- States: IDLE, CFG_DRIVE, CFG_WAIT, HDR_TRIG, HDR_WAIT, TX_START, TX_WAIT, GAP.
- IDLE:
  - i_cfg_req has priority: latch sel/ip, go to CFG_DRIVE.
  - Otherwise, on any i_req bit: select by round-robin (alternate when both are asserted). Latch the length, pulse o_gnt for one cycle, set o_tx_src.
  - If the latched length > MAX_LEN: pulse o_done and o_len_err in the next cycle, then go to GAP with no trigger.
  - Otherwise go to HDR_TRIG.
- CFG_DRIVE: o_ip0..3 drive the latched IP and hold it until leaving CFG_WAIT. o_set_local or o_set_dest (per sel) is high for exactly 2 cycles. Then go to CFG_WAIT.
- CFG_WAIT: on i_hdr_ready, pulse o_cfg_ack and go to GAP.
- HDR_TRIG: o_data_length = latched length, held until leaving HDR_WAIT. o_trig is high for exactly 2 cycles. Then go to HDR_WAIT.
- HDR_WAIT: on i_hdr_ready, go to TX_START.
- Timeout: in CFG_WAIT or HDR_WAIT, a counter starts at 0 on entry. If it reaches TIMEOUT_CYCLES-1 without i_hdr_ready:
  - set o_timeout_err;
  - pulse o_done (frame) or o_cfg_ack (config);
  - go to GAP.
  - i_hdr_ready on that same cycle counts as success, not timeout.
- TX_START: pulse o_tx_start for 1 cycle, then go to TX_WAIT.
- TX_WAIT: wait for i_tx_done; no timeout. On done, pulse o_done[o_tx_src], flip the round-robin pointer, go to GAP.
- i_tx_done and i_hdr_ready outside their wait states are ignored.
- GAP: all strobes low for GAP_CYCLES cycles, then IDLE.
- Requests arriving during a busy transaction are held by the requester and served later; nothing is preempted.
- Minimum frame latency, accept to o_tx_start: 1 (gnt) + 2 (trig) + builder latency + 1.

Optional Feature:
- Macro IP_SCHED_STATS_EN.
- Defined: o_frame_cnt increments on each successful frame o_done (not on rejects or timeouts), saturating at 16'hFFFF; reset to 0.
- Undefined: o_frame_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Config local IP: i_cfg_req=1, sel=0, ip=32'hC0A8010A → o_set_local high 2 cycles, o_ip0..3 = C0,A8,01,0A held; builder-model ready 12 cycles later → o_cfg_ack pulse; o_busy low after GAP.
- Single frame: i_req=2'b01, len0=100 → o_gnt=01, o_data_length=100, o_trig 2 cycles; ready → o_tx_start, o_tx_src=0; i_tx_done → o_done=01.
- Contention: i_req=2'b11 held continuously, and i_cfg_req raised in the same cycle → config served first, then frames in order src 0, 1, 0, 1.
- Oversize: len1=1481 → o_gnt=10, then o_done=10 with o_len_err; o_trig never rises.
- Timeout: builder model never readies → after 64 HDR_WAIT cycles, o_timeout_err=1 sticky and o_done pulse; the next frame proceeds normally.
- Reset: assert i_rst during TX_WAIT → all outputs 0 immediately; after release, a pending req0 is served first; with IP_SCHED_STATS_EN, o_frame_cnt=0 and then counts 1.
